// File: rtl/pc_call_sequencer.sv
// Program counter and return-address stack feeding a combinational instruction ROM.
// Optional macro CALL_DEPTH_MON_EN adds oMaxDepth, a high-water mark of the stack depth.
`ifndef JMP
`define JMP  4'hA
`endif
`ifndef CALL
`define CALL 4'hB
`endif
`ifndef RET
`define RET  4'hC
`endif

module pc_call_sequencer #(
    parameter int          DEPTH    = 8,
    parameter logic [15:0] RESET_PC = 16'd0
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [27:0]                    iInstruction,
    input  logic                           iBranchTaken,
    input  logic                           iStall,
    output logic [15:0]                    oAddress,
    output logic [$clog2(DEPTH+1)-1:0]     oStackDepth,
`ifdef CALL_DEPTH_MON_EN
    output logic [$clog2(DEPTH+1)-1:0]     oMaxDepth,
`endif
    output logic                           oStackError
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   pc_q, pc_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic [15:0]   stack_q [DEPTH];

    logic [3:0]    opcode;
    logic [15:0]   target;
    logic [15:0]   pc_inc;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] push_idx;
    logic          push_en;
    logic          unused_operands;

    assign opcode          = iInstruction[27:24];
    assign target          = {8'h00, iInstruction[23:16]};
    assign pc_inc          = pc_q + 16'd1;
    assign top_idx         = AW'(depth_q - DW'(1));
    assign push_idx        = AW'(depth_q);
    assign unused_operands = ^iInstruction[15:0];

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (!iStall) begin
            if (opcode == `RET) begin
                if (depth_q == '0) begin
                    pc_d  = RESET_PC;
                    err_d = 1'b1;
                end else begin
                    pc_d    = stack_q[top_idx];
                    depth_d = depth_q - DW'(1);
                end
            end else if (opcode == `CALL) begin
                pc_d = target;
                // A full stack still takes the jump; only the return address is lost.
                if (depth_q == DW'(DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    depth_d = depth_q + DW'(1);
                end
            end else if (opcode == `JMP || iBranchTaken) begin
                pc_d = target;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_q    <= RESET_PC;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack storage carries no reset; entries above depth are never read.
    always_ff @(posedge Clock) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

`ifdef CALL_DEPTH_MON_EN
    logic [DW-1:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (depth_d > max_q) begin
            max_d = depth_d;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign oMaxDepth = max_q;
`endif

    assign oAddress    = pc_q;
    assign oStackDepth = depth_q;
    assign oStackError = err_q;

endmodule
